// File: rtl/shared_reg_arbiter_pkg.sv
// Shared types and helpers for the round-robin shared-register arbiter.
package shared_reg_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_t;

    // Width of an index field able to name any of n entries (never zero).
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Next round-robin index; wraps with an explicit compare so n need not be a power of 2.
    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
        return (idx == n - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/shared_reg_arbiter_if.sv
// Requester-facing bus of the shared-register arbiter: requests and data in, grant and register state out.
interface shared_reg_arbiter_if #(
    parameter int WIDTH = 8,
    parameter int NREQ  = 4
);
    localparam int IW = shared_reg_arb_pkg::idx_w(NREQ);

    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] wdata;
    logic [NREQ-1:0]       gnt;
    logic [IW-1:0]         owner;
    logic                  busy;
    logic [WIDTH-1:0]      q;
    logic                  q_valid;

    modport master (
        output req, wdata,
        input  gnt, owner, busy, q, q_valid
    );

    modport slave (
        input  req, wdata,
        output gnt, owner, busy, q, q_valid
    );

endinterface

// File: rtl/shared_reg_arbiter_flopenr.sv
// Enabled register with asynchronous active-high reset.
module flopenr #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)   q <= '0;
        else if (en) q <= d;
    end

endmodule

// File: rtl/shared_reg_arbiter.sv
// Round-robin arbiter granting NREQ requesters bounded tenures on one shared flopenr.
module shared_reg_arbiter
    import shared_reg_arb_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int NREQ     = 4,
    parameter int MAX_HOLD = 4
) (
    input logic                clk,
    input logic                reset,
    shared_reg_arbiter_if.slave bus
);

    localparam int IW = idx_w(NREQ);
    localparam int HW = idx_w(MAX_HOLD);
    localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

    state_t          state, state_d;
    logic [NREQ-1:0] gnt, gnt_d;
    logic [IW-1:0]   owner, owner_d;
    logic [IW-1:0]   ptr, ptr_d;
    logic [HW-1:0]   hold_cnt, hold_d;
    logic [IW-1:0]   winner;
    logic            found;
    logic            req_own;
    logic [WIDTH-1:0] d_own;
    logic [WIDTH-1:0] q;
    logic            q_valid;
    logic            en;

    function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] base, input int unsigned off);
        int unsigned s;
        s = 32'(base) + off;
        return IW'((s >= 32'(NREQ)) ? s - 32'(NREQ) : s);
    endfunction

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        req_own = 1'b0;
        d_own   = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (owner == IW'(i)) begin
                req_own = bus.req[i];
                d_own   = bus.wdata[i*WIDTH +: WIDTH];
            end
        end
    end

    // First requester at or after ptr, wrapping; lowest offset wins.
    always_comb begin
        winner = ptr;
        found  = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (!found && bus.req[wrap_add(ptr, i)]) begin
                winner = wrap_add(ptr, i);
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state;
        gnt_d   = gnt;
        owner_d = owner;
        ptr_d   = ptr;
        hold_d  = hold_cnt;
        en      = 1'b0;
        case (state)
            IDLE: begin
                if (|bus.req) begin
                    state_d = OWN;
                    owner_d = winner;
                    hold_d  = '0;
                    for (int i = 0; i < NREQ; i++) gnt_d[i] = (winner == IW'(i));
                end
            end
            OWN: begin
                en = req_own;
                if (req_own && hold_cnt != HOLD_LAST) begin
                    hold_d = hold_cnt + HW'(1);
                end else begin
                    // Voluntary drop or final permitted write: hand the pointer to the next requester.
                    state_d = IDLE;
                    gnt_d   = '0;
                    ptr_d   = IW'(rr_next(32'(owner), NREQ));
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            gnt      <= '0;
            owner    <= '0;
            ptr      <= '0;
            hold_cnt <= '0;
        end else begin
            state    <= state_d;
            gnt      <= gnt_d;
            owner    <= owner_d;
            ptr      <= ptr_d;
            hold_cnt <= hold_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)  q_valid <= 1'b0;
        else if (en) q_valid <= 1'b1;
    end

    flopenr #(.WIDTH(WIDTH)) u_q (
        .clk   (clk),
        .reset (~reset),
        .en    (en),
        .d     (d_own),
        .q     (q)
    );

    assign bus.gnt     = gnt;
    assign bus.owner   = owner;
    assign bus.busy    = (state == OWN);
    assign bus.q       = q;
    assign bus.q_valid = q_valid;

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Bench for shared_reg_arbiter: directed scenarios plus random traffic against a tenure-level model.
module tb_shared_reg_arbiter;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    shared_reg_arbiter_if #(.WIDTH(8), .NREQ(4)) bus4 ();
    shared_reg_arbiter_if #(.WIDTH(8), .NREQ(3)) bus3 ();

    shared_reg_arbiter #(.WIDTH(8), .NREQ(4), .MAX_HOLD(4)) u_dut4 (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus4)
    );

    shared_reg_arbiter #(.WIDTH(8), .NREQ(3), .MAX_HOLD(1)) u_dut3 (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus3)
    );

    // Reference model: who holds the register, how many writes this tenure, where the search starts next.
    typedef struct {
        bit         busy;
        int         owner;
        int         ptr;
        int         writes;
        logic [7:0] q;
        bit         qv;
    } model_t;

    model_t m4;
    model_t m3;

    function automatic model_t mstep(model_t m, logic [3:0] req, logic [31:0] wd, int n, int maxh);
        model_t r = m;
        if (!r.busy) begin
            for (int i = 0; i < n; i++) begin
                int c = (r.ptr + i) % n;
                if (req[c]) begin
                    r.busy   = 1;
                    r.owner  = c;
                    r.writes = 0;
                    break;
                end
            end
        end else if (req[r.owner]) begin
            r.q      = wd[r.owner*8 +: 8];
            r.qv     = 1;
            r.writes = r.writes + 1;
            if (r.writes == maxh) begin
                r.busy = 0;
                r.ptr  = (r.owner + 1) % n;
            end
        end else begin
            r.busy = 0;
            r.ptr  = (r.owner + 1) % n;
        end
        return r;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m4 <= '{busy: 0, owner: 0, ptr: 0, writes: 0, q: 8'h00, qv: 0};
            m3 <= '{busy: 0, owner: 0, ptr: 0, writes: 0, q: 8'h00, qv: 0};
        end else begin
            m4 <= mstep(m4, bus4.req, bus4.wdata, 4, 4);
            m3 <= mstep(m3, {1'b0, bus3.req}, {8'h00, bus3.wdata}, 3, 1);
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus4.req = '0;
        bus3.req = '0;
        rst_n = 1'b0;
        cycle();
        cycle();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        bus4.req = '0; bus4.wdata = $urandom;
        bus3.req = '0; bus3.wdata = 24'($urandom);
        #2 rst_n = 1'b0;
        for (int c = 0; c < 2; c++) begin
            cycle();
            checks++;
            if ({bus4.gnt, bus4.busy, bus4.q, bus4.q_valid, bus4.owner} !== '0) begin
                errors++;
                $display("FAIL reset_hold cyc %0d: gnt=%b busy=%b q=%h q_valid=%b owner=%0d, expected all zero",
                         c, bus4.gnt, bus4.busy, bus4.q, bus4.q_valid, bus4.owner);
            end
        end
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            cycle();
            checks++;
            if ({bus4.gnt, bus4.busy, bus4.q, bus4.q_valid, bus4.owner} !== '0) begin
                errors++;
                $display("FAIL reset_idle cyc %0d: gnt=%b busy=%b q=%h q_valid=%b owner=%0d, expected all zero",
                         c, bus4.gnt, bus4.busy, bus4.q, bus4.q_valid, bus4.owner);
            end
        end
    endtask

    task automatic test_single_owner();
        bus4.wdata = 32'h0000_00AA;
        bus4.req   = 4'b0001;
        cycle();
        checks++;
        if (bus4.gnt !== 4'b0001 || bus4.busy !== 1'b1 || bus4.q_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_grant: gnt=%b busy=%b q_valid=%b, expected 0001 1 0", bus4.gnt, bus4.busy, bus4.q_valid);
        end
        cycle();
        checks++;
        if (bus4.q !== 8'hAA || bus4.q_valid !== 1'b1) begin
            errors++;
            $display("FAIL single_write1: q=%h q_valid=%b, expected aa 1", bus4.q, bus4.q_valid);
        end
        bus4.wdata = 32'h0000_0055;
        cycle();
        checks++;
        if (bus4.q !== 8'h55 || bus4.gnt !== 4'b0001) begin
            errors++;
            $display("FAIL single_write2: q=%h gnt=%b, expected 55 0001", bus4.q, bus4.gnt);
        end
        bus4.req = 4'b0000;
        cycle();
        checks++;
        if (bus4.gnt !== 4'b0000 || bus4.busy !== 1'b0 || bus4.q !== 8'h55 || bus4.owner !== 2'd0 || bus4.q_valid !== 1'b1) begin
            errors++;
            $display("FAIL single_release: gnt=%b busy=%b q=%h owner=%0d q_valid=%b, expected 0000 0 55 0 1",
                     bus4.gnt, bus4.busy, bus4.q, bus4.owner, bus4.q_valid);
        end
        bus4.req = 4'b1111;
        cycle();
        checks++;
        if (bus4.owner !== 2'd1 || bus4.gnt !== 4'b0010) begin
            errors++;
            $display("FAIL single_ptr_next: owner=%0d gnt=%b, expected 1 0010", bus4.owner, bus4.gnt);
        end
        bus4.req = 4'b0000;
        cycle();
        checks++;
        if (bus4.q !== 8'h55 || bus4.busy !== 1'b0) begin
            errors++;
            $display("FAIL single_no_write_on_drop: q=%h busy=%b, expected 55 0", bus4.q, bus4.busy);
        end
    endtask

    task automatic test_saturate();
        do_reset();
        bus4.wdata = 32'h3322_1100;
        bus4.req   = 4'b1111;
        for (int t = 0; t < 5; t++) begin
            int o = t % 4;
            cycle();
            checks++;
            if (bus4.gnt !== 4'(1 << o) || bus4.owner !== 2'(o)) begin
                errors++;
                $display("FAIL sat_grant tenure %0d: gnt=%b owner=%0d, expected %b %0d", t, bus4.gnt, bus4.owner, 4'(1 << o), o);
            end
            for (int w = 0; w < 4; w++) begin
                cycle();
                checks++;
                if (bus4.q !== 8'(o * 8'h11) || bus4.q_valid !== 1'b1 || bus4.busy !== (w < 3)) begin
                    errors++;
                    $display("FAIL sat_write t%0d w%0d: q=%h q_valid=%b busy=%b, expected %h 1 %0d",
                             t, w, bus4.q, bus4.q_valid, bus4.busy, 8'(o * 8'h11), (w < 3));
                end
            end
        end
        bus4.req = '0;
        cycle();
    endtask

    task automatic test_ignore_nonowner();
        logic [7:0] d1;
        do_reset();
        d1 = 8'h12;
        bus4.wdata = {8'hFF, 8'h00, d1, 8'h00};
        bus4.req   = 4'b1010;
        cycle();
        checks++;
        if (bus4.owner !== 2'd1) begin
            errors++;
            $display("FAIL ignore_grant: owner=%0d, expected 1", bus4.owner);
        end
        for (int k = 0; k < 3; k++) begin
            cycle();
            checks++;
            if (bus4.q !== d1) begin
                errors++;
                $display("FAIL ignore_write %0d: q=%h, expected %h", k, bus4.q, d1);
            end
            d1 = 8'($urandom_range(0, 254));
            bus4.wdata[15:8] = d1;
        end
        bus4.req = 4'b1000;
        cycle();
        checks++;
        if (bus4.busy !== 1'b0 || bus4.q === 8'hFF) begin
            errors++;
            $display("FAIL ignore_release: busy=%b q=%h, expected 0 and q not ff", bus4.busy, bus4.q);
        end
        cycle();
        checks++;
        if (bus4.owner !== 2'd3 || bus4.gnt !== 4'b1000) begin
            errors++;
            $display("FAIL ignore_next: owner=%0d gnt=%b, expected 3 1000", bus4.owner, bus4.gnt);
        end
        cycle();
        checks++;
        if (bus4.q !== 8'hFF) begin
            errors++;
            $display("FAIL ignore_next_write: q=%h, expected ff", bus4.q);
        end
        bus4.req = '0;
        cycle();
    endtask

    task automatic test_wrap_single_hold();
        do_reset();
        bus3.wdata = 24'hC2_B1_A0;
        bus3.req   = 3'b100;
        cycle();
        checks++;
        if (bus3.owner !== 2'd2 || bus3.gnt !== 3'b100) begin
            errors++;
            $display("FAIL wrap_grant2: owner=%0d gnt=%b, expected 2 100", bus3.owner, bus3.gnt);
        end
        cycle();
        checks++;
        if (bus3.q !== 8'hC2 || bus3.busy !== 1'b0) begin
            errors++;
            $display("FAIL wrap_forced: q=%h busy=%b, expected c2 0", bus3.q, bus3.busy);
        end
        bus3.req = 3'b001;
        cycle();
        checks++;
        if (bus3.owner !== 2'd0 || bus3.gnt !== 3'b001) begin
            errors++;
            $display("FAIL wrap_grant0: owner=%0d gnt=%b, expected 0 001", bus3.owner, bus3.gnt);
        end
        cycle();
        checks++;
        if (bus3.q !== 8'hA0 || bus3.busy !== 1'b0) begin
            errors++;
            $display("FAIL wrap_hold1: q=%h busy=%b, expected a0 0", bus3.q, bus3.busy);
        end
        cycle();
        checks++;
        if (bus3.owner !== 2'd0 || bus3.busy !== 1'b1) begin
            errors++;
            $display("FAIL wrap_regrant: owner=%0d busy=%b, expected 0 1", bus3.owner, bus3.busy);
        end
        bus3.req = '0;
        cycle();
        cycle();
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 3) == 0) bus4.req = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) bus3.req = 3'($urandom_range(0, 7));
            bus4.wdata = $urandom;
            bus3.wdata = 24'($urandom);
            cycle();
            checks++;
            if (bus4.gnt !== (m4.busy ? 4'(1 << m4.owner) : 4'h0) || bus4.owner !== 2'(m4.owner) ||
                bus4.busy !== m4.busy || bus4.q !== m4.q || bus4.q_valid !== m4.qv) begin
                errors++;
                $display("FAIL rand4 cyc %0d: gnt=%b owner=%0d busy=%b q=%h qv=%b, expected busy=%0d owner=%0d q=%h qv=%0d",
                         c, bus4.gnt, bus4.owner, bus4.busy, bus4.q, bus4.q_valid, m4.busy, m4.owner, m4.q, m4.qv);
            end
            checks++;
            if (bus3.gnt !== (m3.busy ? 3'(1 << m3.owner) : 3'h0) || bus3.owner !== 2'(m3.owner) ||
                bus3.busy !== m3.busy || bus3.q !== m3.q || bus3.q_valid !== m3.qv || bus3.owner > 2'd2) begin
                errors++;
                $display("FAIL rand3 cyc %0d: gnt=%b owner=%0d busy=%b q=%h qv=%b, expected busy=%0d owner=%0d q=%h qv=%0d",
                         c, bus3.gnt, bus3.owner, bus3.busy, bus3.q, bus3.q_valid, m3.busy, m3.owner, m3.q, m3.qv);
            end
        end
        bus4.req = '0;
        bus3.req = '0;
        cycle();
        cycle();
    endtask

    task automatic test_async_reset();
        do_reset();
        bus4.wdata = 32'h5A4B_3C2D;
        bus4.req   = 4'b0010;
        cycle();
        cycle();
        bus4.req = 4'b0000;
        cycle();
        bus4.req = 4'b0100;
        cycle();
        cycle();
        checks++;
        if (bus4.owner !== 2'd2 || bus4.busy !== 1'b1 || bus4.q !== 8'h4B || bus4.q_valid !== 1'b1) begin
            errors++;
            $display("FAIL async_setup: owner=%0d busy=%b q=%h qv=%b, expected 2 1 4b 1", bus4.owner, bus4.busy, bus4.q, bus4.q_valid);
        end
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if ({bus4.gnt, bus4.busy, bus4.q, bus4.q_valid, bus4.owner} !== '0) begin
            errors++;
            $display("FAIL async_reset_now: gnt=%b busy=%b q=%h q_valid=%b owner=%0d, expected all zero",
                     bus4.gnt, bus4.busy, bus4.q, bus4.q_valid, bus4.owner);
        end
        bus4.req = 4'b1111;
        cycle();
        rst_n = 1'b1;
        cycle();
        checks++;
        if (bus4.owner !== 2'd0 || bus4.gnt !== 4'b0001) begin
            errors++;
            $display("FAIL async_restart: owner=%0d gnt=%b, expected 0 0001", bus4.owner, bus4.gnt);
        end
        bus4.req = '0;
        cycle();
    endtask

    initial begin
        bus4.req = '0; bus4.wdata = '0;
        bus3.req = '0; bus3.wdata = '0;
        test_reset();
        test_single_owner();
        test_saturate();
        test_ignore_nonowner();
        test_wrap_single_hold();
        test_random();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/shared_reg_arbiter.md
Name: shared_reg_arbiter

Overview:
Round-robin arbiter sharing one WIDTH-bit enabled register (flopenr) among NREQ requesters. It selects an owner, steers that owner's write data onto the register d input, and drives the register enable while the owner keeps requesting. A hold limit prevents starvation. It sits in front of any flopenr-backed state that several producers must update.

Parameters:
WIDTH, 8, data width of the shared register
NREQ, 4, number of requesters; must be >= 2 (need not be a power of 2)
MAX_HOLD, 4, maximum writes per tenure; must be >= 1

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
req  in  NREQ  per-requester request/write strobe
wdata  in  NREQ*WIDTH  packed write data; requester i uses bits [i*WIDTH +: WIDTH]
gnt  out  NREQ  registered one-hot grant; all zero when no owner
owner  out  $clog2(NREQ)  index of current or most recent owner
busy  out  1  high while in OWN
q  out  WIDTH  shared register contents
q_valid  out  1  sticky; high once the first write has completed

Behaviour:
- Reset (reset=0, asynchronous) forces the following, regardless of the state at assertion:
  - state=IDLE, gnt=0, owner=0, busy=0, ptr=0, hold_cnt=0, q=0, q_valid=0.
- State IDLE:
  - If req != 0 at an edge, pick the first set bit searching ptr, ptr+1, ... with wrap modulo NREQ.
  - At that edge: gnt<=onehot(winner), owner<=winner, hold_cnt<=0, state<=OWN.
  - No write occurs in IDLE; register en=0.
- State OWN:
  - Register en = req[owner]; register d = wdata[owner] (combinational mux).
  - Each edge with req[owner]=1 writes q, sets q_valid=1, and increments hold_cnt.
- Release, either case: state<=IDLE, gnt<=0, ptr<=(owner+1) mod NREQ. owner holds its value.
  - Voluntary: req[owner]=0 at an edge; no write that edge.
  - Forced: req[owner]=1 and hold_cnt==MAX_HOLD-1. The write still occurs, giving exactly MAX_HOLD writes per tenure.
- IDLE always lasts at least one cycle between tenures. Grant-to-grant minimum is therefore MAX_HOLD+1 cycles under saturation.
- Requests from non-owners during OWN are ignored and their wdata is never written.
- Requester latency: the first write lands on the second rising edge after req rises, provided the arbiter is IDLE and the requester wins.
- Wrap: ptr equal to NREQ-1 followed by a release sets ptr to 0. Explicit compare, no reliance on power-of-2 overflow.
- MAX_HOLD=1: every tenure is exactly one write then a forced release.
- busy equals (state==OWN); gnt is nonzero iff busy.

Decomposition:
- Package shared_reg_arb_pkg: state enum (IDLE, OWN), a function returning the next round-robin index with modulo-NREQ wrap, and a width helper for the owner and ptr fields.
- Sub-module: the existing flopenr #(WIDTH), instantiated once for q.
  - Its active-high reset input is driven by the inverted block reset.
  - Arbiter FSM, ptr and hold_cnt live in shared_reg_arbiter.

Test Plan:
- Hold reset=0 for 2 cycles, then release with req=0 -> gnt=0, busy=0, q=00, q_valid=0, owner=0 for 5 cycles.
- req=0001 held, wdata0=AA, then 55 after the first write, then req drops; MAX_HOLD=4 -> gnt=0001 one edge after req, q=AA then 55, voluntary release, ptr=1, q_valid=1.
- req=1111 held constantly, each wdata_i=i*0x11 -> owners 0,1,2,3,0 in that order. Each tenure has exactly 4 writes (q=00, 11, 22, 33 ...) and 1 IDLE cycle between tenures.
- NREQ=3, req=100 then 001 after release -> ptr wraps 2->0, requester 0 granted; no index 3 ever appears.
- Owner 1 active, req[3] also high with wdata3=FF -> q never equals FF during owner 1's tenure; requester 3 is granted next.
- Drop reset to 0 mid-tenure, asynchronously between edges -> q=00, gnt=0, busy=0, q_valid=0 immediately. After release, arbitration restarts from ptr=0.
